imem_loader: RTL and testbench

Boot-time program loader sitting upstream of the `cpu` instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them sequentially into the instruction memory write port. It holds the CPU in reset until a complete frame has been loaded, replacing the simulation-only `$readmemh` path with a synthesizable one.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/word_assembler.sv | 41 ++++
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam int HDR_BYTES         = 2;
  localparam int MAX_WORDS_DEFAULT = 256;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted bytes LSB-first into 32-bit words and presents each completed
// word with a registered one-cycle word_valid.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  rx_byte,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        word_last
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift;

  // Combinational so the parent can act on the completing byte in the same cycle.
  assign word_last = accept && (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= 2'd0;
      shift      <= 24'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_cnt <= 2'd0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= {rx_byte, shift[23:8]};
        if (byte_cnt == 2'd3) begin
          word       <= {rx_byte, shift};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a framed byte image into the instruction memory and holds the CPU in
// reset until the frame is complete. Define IMEM_LOADER_CSUM_EN for an XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  loader_state_t state, state_next;
  logic [7:0]    count_lo;
  logic [15:0]   count;
  logic [15:0]   hdr_n;
  logic          accept;
  logic          start_ok;
  logic          data_accept;
  logic          word_last;
  logic          last_word;

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] csum;
`endif

  assign accept      = rx_valid && rx_ready;
  assign start_ok    = start && (state == IDLE || state == DONE || state == ERR);
  assign data_accept = accept && (state == DATA);
  assign hdr_n       = {rx_data, count_lo};
  assign last_word   = (32'(words_loaded) + 32'd1) == 32'(count);

  assign rx_ready = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CSUM);
  assign busy     = rx_ready;
  assign done     = (state == DONE);
  assign err      = (state == ERR);

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .accept     (data_accept),
    .rx_byte    (rx_data),
    .word       (imem_wdata),
    .word_valid (imem_we),
    .word_last  (word_last)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_next = HDR0;
      HDR0:            if (accept) state_next = HDR1;
      HDR1: begin
        if (accept) begin
          if (hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          end else if ({1'b0, hdr_n} > MAX_N) begin
            state_next = ERR;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (word_last && last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_next = CSUM;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: if (accept) state_next = (rx_data == csum) ? DONE : ERR;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count_lo     <= 8'd0;
      count        <= 16'd0;
      words_loaded <= '0;
      imem_waddr   <= '0;
      cpu_rst_n    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && state == HDR0) count_lo <= rx_data;
      if (accept && state == HDR1) count <= hdr_n;
      if (start_ok) begin
        words_loaded <= '0;
      end else if (word_last) begin
        words_loaded <= words_loaded + {{ADDR_W{1'b0}}, 1'b1};
        imem_waddr   <= words_loaded[ADDR_W-1:0];
      end
      // Release the CPU one cycle after DONE; pull it back the cycle after a restart.
      cpu_rst_n <= (state == DONE) && !start_ok;
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= 8'd0;
    end else if (start_ok) begin
      csum <= 8'd0;
    end else if (accept && (state == HDR0 || state == HDR1 || state == DATA)) begin
      csum <= csum ^ rx_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as frames are
// built and popped whenever the loader strobes imem_we.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 8;
  localparam int MAX_W  = 256;
`ifdef IMEM_LOADER_CSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         sb[$];
  logic [7:0]  frame[$];
  logic [31:0] words[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          start_cyc = 0;

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_rst_n    (cpu_rst_n),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_we", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        checkOutput("waddr", 32'(imem_waddr), 32'(e.addr));
        checkOutput("wdata", imem_wdata, e.data);
      end
    end
  end

  task automatic buildFrame(input int n, input bit bad_csum, input int limit);
    logic [15:0] nn;
    logic [7:0]  x;
    int          pay;
    int          sent;
    wr_t         e;
    nn = 16'(n);
    x  = 8'd0;
    frame.delete();
    frame.push_back(nn[7:0]);
    frame.push_back(nn[15:8]);
    x = nn[7:0] ^ nn[15:8];
    if (n <= MAX_W) begin
      for (int i = 0; i < n; i++) begin
        for (int b = 0; b < 4; b++) begin
          logic [31:0] w;
          w = words[i] >> (8 * b);
          frame.push_back(w[7:0]);
          x = x ^ w[7:0];
        end
      end
      if (CSUM_BYTES == 1) frame.push_back(bad_csum ? ~x : x);
    end
    while (frame.size() > limit) void'(frame.pop_back());
    if (n <= MAX_W) begin
      pay  = frame.size() - HDR_BYTES;
      sent = (pay > 0) ? pay / 4 : 0;
      if (sent > n) sent = n;
      for (int i = 0; i < sent; i++) begin
        e.addr = ADDR_W'(i);
        e.data = words[i];
        sb.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input bit bubbles);
    int idx;
    int guard;
    bit hold;
    bit take;
    idx   = 0;
    guard = 0;
    hold  = bubbles;
    @(posedge clk); #1;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (idx < frame.size() && guard < 4000) begin
      rx_valid = !hold;
      rx_data  = frame[idx];
      @(negedge clk);
      take = rx_valid && rx_ready;
      @(posedge clk); #1;
      if (take) idx++;
      if (bubbles) hold = !hold;
      guard++;
    end
    rx_valid = 1'b0;
    if (idx < frame.size()) checkOutput("rx_timeout", 32'(idx), 32'(frame.size()));
  endtask

  task automatic waitDone(input int n, input int exp_cycle);
    int k;
    k = 0;
    @(negedge clk);
    while (!done && !err && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput("done", 32'(done), 32'd1);
    checkOutput("err_clear", 32'(err), 32'd0);
    checkOutput("done_cycle", 32'(cyc - start_cyc), 32'(exp_cycle));
    checkOutput("cpu_rst_n_at_done", 32'(cpu_rst_n), 32'd0);
    checkOutput("words_loaded", 32'(words_loaded), 32'(n));
    @(negedge clk);
    checkOutput("cpu_rst_n_after", 32'(cpu_rst_n), 32'd1);
    checkOutput("wr_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_we"}, 32'(imem_we), 32'd0);
    checkOutput({tag, "_waddr"}, 32'(imem_waddr), 32'd0);
    checkOutput({tag, "_wdata"}, imem_wdata, 32'd0);
    checkOutput({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_ready"}, 32'(rx_ready), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    words.push_back(32'h00A00093);
    words.push_back(32'h00100113);
    base = HDR_BYTES + 4 * 2 + CSUM_BYTES;

    #12;
    checkIdleOutputs("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;

    $display("[TB] frame N=2 streamed");
    buildFrame(2, 1'b0, 1000);
    applyStimulus(1'b0);
    waitDone(2, base + 1);

    $display("[TB] frame N=2 with bubbles");
    buildFrame(2, 1'b0, 1000);
    applyStimulus(1'b1);
    waitDone(2, 2 * base + 1);

    $display("[TB] frame N=0");
    buildFrame(0, 1'b0, 1000);
    applyStimulus(1'b0);
    waitDone(0, HDR_BYTES + CSUM_BYTES + 1);

    $display("[TB] frame N=300 rejected");
    buildFrame(300, 1'b0, 1000);
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("big_err", 32'(err), 32'd1);
    checkOutput("big_done", 32'(done), 32'd0);
    checkOutput("big_ready", 32'(rx_ready), 32'd0);
    checkOutput("big_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("big_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    buildFrame(2, 1'b0, 1000);
    applyStimulus(1'b0);
    waitDone(2, base + 1);

    $display("[TB] reset mid-frame");
    buildFrame(2, 1'b0, HDR_BYTES + 5);
    applyStimulus(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("midrst");
    #2;
    rst_n = 1'b1;
    checkOutput("midrst_pending", 32'(sb.size()), 32'd0);
    buildFrame(2, 1'b0, 1000);
    applyStimulus(1'b0);
    waitDone(2, base + 1);

`ifdef IMEM_LOADER_CSUM_EN
    $display("[TB] corrupted checksum");
    buildFrame(2, 1'b1, 1000);
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("csum_err", 32'(err), 32'd1);
    checkOutput("csum_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("csum_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("csum_pending", 32'(sb.size()), 32'd0);
    buildFrame(2, 1'b0, 1000);
    applyStimulus(1'b0);
    waitDone(2, base + 1);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
